// File: rtl/apb_cmd_master_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | apb_cmd_master_pkg : shared types and widths for the APB cmd master  |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
package apb_cmd_master_pkg;

  // Widths mirror the MCU configuration; only 32-bit data is supported.
  localparam int unsigned c_apb_addr_width = 32;
  localparam int unsigned c_apb_data_width = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_t;

  typedef struct packed {
    logic [c_apb_data_width-1:0] rdata;
    logic                        err;
    logic                        timeout;
  } rsp_t;

endpackage
`default_nettype wire

// File: rtl/apb_timeout_cnt.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | apb_timeout_cnt : saturating ACCESS-phase wait counter               |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
module apb_timeout_cnt #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  generate
    if (TIMEOUT_CYCLES == 0) begin : g_disabled
      logic w_unused;
      assign w_unused  = clk ^ rst ^ i_clear ^ i_enable;
      assign o_expired = 1'b0;
    end else begin : g_enabled
      localparam int unsigned       c_cnt_w = $clog2(TIMEOUT_CYCLES + 1);
      localparam logic [c_cnt_w-1:0] c_limit = c_cnt_w'(TIMEOUT_CYCLES);

      logic [c_cnt_w-1:0] r_cnt;

      // Holds at the limit rather than wrapping, so expiry cannot be missed.
      always_ff @(posedge clk) begin
        if (rst || i_clear) begin
          r_cnt <= '0;
        end else if (i_enable && (r_cnt != c_limit)) begin
          r_cnt <= r_cnt + c_cnt_w'(1);
        end
      end

      assign o_expired = (r_cnt == c_limit);
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/apb_cmd_master.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | apb_cmd_master : valid/ready command port to single APB3 transfers   |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
module apb_cmd_master
  import apb_cmd_master_pkg::*;
#(
  parameter int unsigned APB_ADDR_WIDTH = c_apb_addr_width,
  parameter int unsigned APB_DATA_WIDTH = c_apb_data_width,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      req_valid_i,
  output logic                      req_ready_o,
  input  logic                      req_write_i,
  input  logic [APB_ADDR_WIDTH-1:0] req_addr_i,
  input  logic [APB_DATA_WIDTH-1:0] req_wdata_i,
  output logic                      rsp_valid_o,
  input  logic                      rsp_ready_i,
  output logic [APB_DATA_WIDTH-1:0] rsp_rdata_o,
  output logic                      rsp_err_o,
  output logic                      rsp_timeout_o,
  output logic [APB_ADDR_WIDTH-1:0] paddr_o,
  output logic [APB_DATA_WIDTH-1:0] pwdata_o,
  output logic                      pwrite_o,
  output logic                      psel_o,
  output logic                      penable_o,
  input  logic [APB_DATA_WIDTH-1:0] prdata_i,
  input  logic                      pready_i,
  input  logic                      pslverr_i
);

  state_t                    r_state;
  state_t                    w_state_next;
  logic [APB_ADDR_WIDTH-1:0] r_addr;
  logic [APB_DATA_WIDTH-1:0] r_wdata;
  logic                      r_write;
  rsp_t                      r_rsp;

  logic w_accept;
  logic w_misaligned;
  logic w_in_apb;
  logic w_in_access;
  logic w_in_resp;
  logic w_expired;
  logic w_abort;

  assign w_accept     = (r_state == IDLE) && req_valid_i;
  assign w_misaligned = (req_addr_i[1:0] != 2'b00);
  assign w_in_apb     = (r_state == SETUP) || (r_state == ACCESS);
  assign w_in_access  = (r_state == ACCESS);
  assign w_in_resp    = (r_state == RESP);
  // A completing PREADY takes priority over a coincident expiry.
  assign w_abort      = w_in_access && !pready_i && w_expired;

  apb_timeout_cnt #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timeout_cnt (
    .clk       (clk),
    .rst       (rst),
    .i_clear   (w_accept),
    .i_enable  (w_in_access && !pready_i),
    .o_expired (w_expired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (req_valid_i) w_state_next = w_misaligned ? RESP : SETUP;
      SETUP:   w_state_next = ACCESS;
      ACCESS:  if (pready_i || w_abort) w_state_next = RESP;
      RESP:    if (rsp_ready_i) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr  <= '0;
      r_wdata <= '0;
      r_write <= 1'b0;
      r_rsp   <= '0;
    end else if (w_accept) begin
      r_addr  <= req_addr_i;
      r_wdata <= req_wdata_i;
      r_write <= req_write_i;
      r_rsp   <= '{rdata: '0, err: w_misaligned, timeout: 1'b0};
    end else if (w_in_access && pready_i) begin
      r_rsp.rdata   <= (r_write || pslverr_i) ? '0 : prdata_i;
      r_rsp.err     <= pslverr_i;
      r_rsp.timeout <= 1'b0;
    end else if (w_abort) begin
      r_rsp <= '{rdata: '0, err: 1'b1, timeout: 1'b1};
    end
  end

  // Bus and response fields are masked by state so idle outputs read as zero.
  assign req_ready_o   = (r_state == IDLE);
  assign psel_o        = w_in_apb;
  assign penable_o     = w_in_access;
  assign paddr_o       = w_in_apb ? r_addr : '0;
  assign pwdata_o      = w_in_apb ? r_wdata : '0;
  assign pwrite_o      = w_in_apb && r_write;
  assign rsp_valid_o   = w_in_resp;
  assign rsp_rdata_o   = w_in_resp ? r_rsp.rdata : '0;
  assign rsp_err_o     = w_in_resp && r_rsp.err;
  assign rsp_timeout_o = w_in_resp && r_rsp.timeout;

endmodule
`default_nettype wire

// File: tb/tb_apb_cmd_master.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_apb_cmd_master : directed and randomized bench for apb_cmd_master |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
module tb_apb_cmd_master;

  localparam int c_tmo = 4;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        rsp_timeout;
  logic [31:0] paddr;
  logic [31:0] pwdata;
  logic        pwrite;
  logic        psel;
  logic        penable;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;

  apb_cmd_master #(
    .APB_ADDR_WIDTH (32),
    .APB_DATA_WIDTH (32),
    .TIMEOUT_CYCLES (c_tmo)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid_i   (req_valid),
    .req_ready_o   (req_ready),
    .req_write_i   (req_write),
    .req_addr_i    (req_addr),
    .req_wdata_i   (req_wdata),
    .rsp_valid_o   (rsp_valid),
    .rsp_ready_i   (rsp_ready),
    .rsp_rdata_o   (rsp_rdata),
    .rsp_err_o     (rsp_err),
    .rsp_timeout_o (rsp_timeout),
    .paddr_o       (paddr),
    .pwdata_o      (pwdata),
    .pwrite_o      (pwrite),
    .psel_o        (psel),
    .penable_o     (penable),
    .prdata_i      (prdata),
    .pready_i      (pready),
    .pslverr_i     (pslverr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   n_vec = 0;
  int   n_err = 0;
  logic chk_en = 1'b0;

  // Transaction-level model: m_busy while an APB transfer is on the bus,
  // m_age counts cycles since acceptance (1 = setup, >=2 = access phase).
  logic        m_busy, m_pend, m_wr, m_err, m_to;
  int          m_age, m_pend_age;
  logic [31:0] m_addr, m_wdata, m_rdata;

  always @(posedge clk) begin
    if (rst) begin
      m_busy <= 1'b0; m_pend <= 1'b0; m_age <= 0; m_pend_age <= 0;
      m_wr <= 1'b0; m_addr <= '0; m_wdata <= '0;
      m_rdata <= '0; m_err <= 1'b0; m_to <= 1'b0;
    end else if (m_pend) begin
      m_pend_age <= m_pend_age + 1;
      if (rsp_ready) m_pend <= 1'b0;
    end else if (m_busy) begin
      if (m_age >= 2 && pready) begin
        m_busy <= 1'b0; m_pend <= 1'b1; m_pend_age <= 0;
        m_err <= pslverr; m_to <= 1'b0;
        m_rdata <= (m_wr || pslverr) ? 32'h0 : prdata;
      end else if (m_age >= 2 && (m_age - 2) == c_tmo) begin
        m_busy <= 1'b0; m_pend <= 1'b1; m_pend_age <= 0;
        m_err <= 1'b1; m_to <= 1'b1; m_rdata <= 32'h0;
      end else begin
        m_age <= m_age + 1;
      end
    end else if (req_valid) begin
      m_wr <= req_write; m_addr <= req_addr; m_wdata <= req_wdata;
      m_rdata <= 32'h0; m_to <= 1'b0;
      if (req_addr[1:0] != 2'b00) begin
        m_pend <= 1'b1; m_pend_age <= 0; m_err <= 1'b1;
      end else begin
        m_busy <= 1'b1; m_age <= 1; m_err <= 1'b0;
      end
    end
  end

  logic [102:0] exp_v, got_v;
  always @(negedge clk) begin
    if (chk_en) begin
      exp_v = {!m_busy && !m_pend, m_busy, m_busy && (m_age >= 2), m_busy && m_wr,
               m_busy ? m_addr : 32'h0, m_busy ? m_wdata : 32'h0,
               m_pend, m_pend && m_err, m_pend && m_to, m_pend ? m_rdata : 32'h0};
      got_v = {req_ready, psel, penable, pwrite, paddr, pwdata,
               rsp_valid, rsp_err, rsp_timeout, rsp_rdata};
      n_vec++;
      if (got_v !== exp_v) begin
        n_err++;
        $display("FAIL outputs @%0t: got %h want %h (rdy/sel/en/wr/addr/wdata/rv/err/to/rdata)",
                 $time, got_v, exp_v);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  task automatic quiet();
    rst = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
    rsp_ready = 1'b0; prdata = '0; pready = 1'b0; pslverr = 1'b0;
  endtask

  // Drives one command and plays the APB slave: PREADY lands on cycle 2+waits
  // after acceptance; elsewhere PREADY/PSLVERR/PRDATA carry noise that must be ignored.
  task automatic run_txn(
    input  logic wr, input logic [31:0] addr, input logic [31:0] wdata,
    input  int waits, input logic serr, input logic [31:0] rdata,
    input  int hold, input int rst_at,
    output int first_psel, output int last_psel, output int first_rsp, output int n_rsp,
    output logic [31:0] got_rdata, output logic got_err, output logic got_to);
    first_psel = -1; last_psel = -1; first_rsp = -1; n_rsp = 0;
    got_rdata = '0; got_err = 1'b0; got_to = 1'b0;
    req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wdata;
    for (int c = 1; c <= 120; c++) begin
      @(posedge clk); #1;
      if (!m_busy && !m_pend) begin
        quiet();
        return;
      end
      rst       = (c == rst_at);
      req_valid = 1'($urandom_range(0, 1));
      req_write = 1'($urandom_range(0, 1));
      req_addr  = $urandom;
      req_wdata = $urandom;
      if (c == 2 + waits) begin
        pready = 1'b1; pslverr = serr; prdata = rdata;
      end else begin
        pready  = (m_busy && m_age >= 2) ? 1'b0 : 1'($urandom_range(0, 1));
        pslverr = 1'($urandom_range(0, 1));
        prdata  = $urandom;
      end
      rsp_ready = m_pend ? (m_pend_age >= hold) : 1'($urandom_range(0, 1));
      @(negedge clk);
      if (psel) begin
        if (first_psel < 0) first_psel = c;
        last_psel = c;
      end
      if (rsp_valid) begin
        n_rsp++;
        if (first_rsp < 0) begin
          first_rsp = c; got_rdata = rsp_rdata; got_err = rsp_err; got_to = rsp_timeout;
        end
      end
    end
    n_vec++; n_err++;
    $display("FAIL txn_bound: got no return to idle within 120 cycles, want idle");
    quiet();
  endtask

  int          fp, lp, fr, nr;
  logic [31:0] gd;
  logic        ge, gt;
  logic        r_wr, r_serr;
  logic [31:0] r_addr, r_wdata, r_rdata;
  int          r_waits, r_hold, r_rst;

  initial begin
    quiet();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 chk_en = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_req_ready", 32'(req_ready), 32'd1);
    chk("reset_psel", 32'(psel), 32'd0);
    chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset_paddr", paddr, 32'h0);

    // Zero-wait write.
    run_txn(1'b1, 32'h1A10_0004, 32'hDEAD_BEEF, 0, 1'b0, 32'hCAFE_F00D, 0, -1,
            fp, lp, fr, nr, gd, ge, gt);
    chk("wr_first_psel", 32'(fp), 32'd1);
    chk("wr_last_psel", 32'(lp), 32'd2);
    chk("wr_rsp_cycle", 32'(fr), 32'd3);
    chk("wr_rsp_err", 32'(ge), 32'd0);
    chk("wr_rsp_rdata", gd, 32'h0);

    // Read with three wait states.
    run_txn(1'b0, 32'h1A10_0008, 32'h0, 3, 1'b0, 32'h1234_5678, 0, -1,
            fp, lp, fr, nr, gd, ge, gt);
    chk("rd_wait_last_psel", 32'(lp), 32'd5);
    chk("rd_wait_rsp_cycle", 32'(fr), 32'd6);
    chk("rd_wait_rdata", gd, 32'h1234_5678);
    chk("rd_wait_err", 32'(ge), 32'd0);

    // Read answered with PSLVERR.
    run_txn(1'b0, 32'h1A10_000C, 32'h0, 1, 1'b1, 32'h5555_AAAA, 1, -1,
            fp, lp, fr, nr, gd, ge, gt);
    chk("slverr_rsp_cycle", 32'(fr), 32'd4);
    chk("slverr_err", 32'(ge), 32'd1);
    chk("slverr_timeout", 32'(gt), 32'd0);
    chk("slverr_rdata", gd, 32'h0);

    // Timeout: PREADY arrives only long after the abort, during the response.
    run_txn(1'b0, 32'h1A10_0010, 32'h0, 8, 1'b0, 32'h9999_9999, 5, -1,
            fp, lp, fr, nr, gd, ge, gt);
    chk("tmo_last_psel", 32'(lp), 32'd6);
    chk("tmo_rsp_cycle", 32'(fr), 32'd7);
    chk("tmo_err", 32'(ge), 32'd1);
    chk("tmo_timeout", 32'(gt), 32'd1);
    chk("tmo_rdata", gd, 32'h0);

    // Misaligned address with a stalled response consumer.
    run_txn(1'b1, 32'h1A10_0002, 32'h1111_2222, 0, 1'b0, 32'h0, 5, -1,
            fp, lp, fr, nr, gd, ge, gt);
    chk("misal_no_psel", 32'(fp), 32'hFFFF_FFFF);
    chk("misal_rsp_cycle", 32'(fr), 32'd1);
    chk("misal_err", 32'(ge), 32'd1);
    chk("misal_rsp_cycles", 32'(nr), 32'd6);

    // Reset asserted during the access phase drops the transfer.
    run_txn(1'b1, 32'h1A10_0020, 32'h0BAD_0BAD, 10, 1'b0, 32'h0, 0, 3,
            fp, lp, fr, nr, gd, ge, gt);
    @(negedge clk);
    chk("rst_mid_psel", 32'(psel), 32'd0);
    chk("rst_mid_penable", 32'(penable), 32'd0);
    chk("rst_mid_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_mid_req_ready", 32'(req_ready), 32'd1);
    chk("rst_mid_no_rsp", 32'(fr), 32'hFFFF_FFFF);
    run_txn(1'b1, 32'h1A10_0024, 32'h0123_4567, 0, 1'b0, 32'h0, 0, -1,
            fp, lp, fr, nr, gd, ge, gt);
    chk("post_rst_rsp_cycle", 32'(fr), 32'd3);
    chk("post_rst_err", 32'(ge), 32'd0);

    // Randomized traffic, checked every cycle against the model.
    for (int n = 0; n < 60; n++) begin
      r_wr    = 1'($urandom_range(0, 1));
      r_addr  = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(0, 5) == 0) r_addr = r_addr | 32'($urandom_range(1, 3));
      r_wdata = $urandom;
      r_waits = $urandom_range(0, 7);
      r_serr  = ($urandom_range(0, 3) == 0);
      r_rdata = $urandom;
      r_hold  = $urandom_range(0, 3);
      r_rst   = ($urandom_range(0, 11) == 0) ? $urandom_range(1, 5) : -1;
      run_txn(r_wr, r_addr, r_wdata, r_waits, r_serr, r_rdata, r_hold, r_rst,
              fp, lp, fr, nr, gd, ge, gt);
    end

    repeat (2) @(posedge clk);
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
